// File: rtl/wheel_integrator.sv
// wheel_integrator: per-node force accumulator and velocity/position integrator.
// Loads post-collision node state, sums gravity plus NUM_SOURCES independent
// force streams per node, then walks the nodes once, applying the mass/timestep
// shift, velocity saturation and optional position integration.
module wheel_integrator #(
  parameter int NUM_NODES     = 16,
  parameter int NUM_SOURCES   = 3,
  parameter int POSITION_SIZE = 16,
  parameter int VELOCITY_SIZE = 16,
  parameter int FORCE_SIZE    = 16,
  parameter int DT            = 4,
  parameter int MASS_SHIFT    = 0,
  parameter int GRAVITY_X     = 0,
  parameter int GRAVITY_Y     = -16,
  parameter int VEL_LIMIT     = 1000,
  parameter int INTEGRATE_POS = 1
) (
  input  logic                                    clk_in,
  input  logic                                    rst_in,
  input  logic                                    begin_in,
  input  logic [NUM_SOURCES-1:0]                  source_enable,
  input  logic [POSITION_SIZE-1:0]                node_in_x,
  input  logic [POSITION_SIZE-1:0]                node_in_y,
  input  logic [VELOCITY_SIZE-1:0]                vel_in_x,
  input  logic [VELOCITY_SIZE-1:0]                vel_in_y,
  input  logic                                    node_in_valid,
  input  logic [NUM_SOURCES-1:0][FORCE_SIZE-1:0]  force_x_in,
  input  logic [NUM_SOURCES-1:0][FORCE_SIZE-1:0]  force_y_in,
  input  logic [NUM_SOURCES-1:0]                  force_valid_in,
  input  logic [NUM_SOURCES-1:0]                  force_done_in,
  output logic [POSITION_SIZE-1:0]                node_out_x,
  output logic [POSITION_SIZE-1:0]                node_out_y,
  output logic [VELOCITY_SIZE-1:0]                velocity_out_x,
  output logic [VELOCITY_SIZE-1:0]                velocity_out_y,
  output logic                                    out_valid,
  output logic                                    result_out,
  output logic                                    error_out,
  output logic [3+NUM_SOURCES-1:0]                states
);

  // Totals carry gravity plus one term per source without overflow.
  localparam int TW = FORCE_SIZE + $clog2(NUM_SOURCES + 2);
  localparam int CW = $clog2(NUM_NODES + 1);
  localparam int IW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int SW = ((VELOCITY_SIZE > TW) ? VELOCITY_SIZE : TW) + 1;
  localparam int QW = (POSITION_SIZE > VELOCITY_SIZE) ? POSITION_SIZE : VELOCITY_SIZE;
  localparam int SH = DT + MASS_SHIFT;

  localparam logic [CW-1:0]        LAST   = CW'(NUM_NODES - 1);
  localparam logic [CW-1:0]        FULL   = CW'(NUM_NODES);
  localparam logic signed [SW-1:0] VLIM_P = SW'(VEL_LIMIT);
  localparam logic signed [SW-1:0] VLIM_N = -VLIM_P;
  localparam logic signed [TW-1:0] GRAV_X = TW'(GRAVITY_X);
  localparam logic signed [TW-1:0] GRAV_Y = TW'(GRAVITY_Y);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_ACCUM     = 3'd2;
  localparam logic [2:0] S_INTEGRATE = 3'd3;

  // v' = sat(v + (total >>> SH)); the sum is one bit wider than either operand.
  function automatic logic signed [VELOCITY_SIZE-1:0] next_vel(
    input logic signed [VELOCITY_SIZE-1:0] v,
    input logic signed [TW-1:0]            tot
  );
    logic signed [TW-1:0] a;
    logic signed [SW-1:0] sum;
    a   = tot >>> SH;
    sum = SW'(v) + SW'(a);
    if (sum > VLIM_P) begin
      next_vel = VELOCITY_SIZE'(VLIM_P);
    end else if (sum < VLIM_N) begin
      next_vel = VELOCITY_SIZE'(VLIM_N);
    end else begin
      next_vel = VELOCITY_SIZE'(sum);
    end
  endfunction

  // p' = p + (v' >>> DT), wrapping at the position width.
  function automatic logic signed [POSITION_SIZE-1:0] next_pos(
    input logic signed [POSITION_SIZE-1:0] p,
    input logic signed [VELOCITY_SIZE-1:0] vn
  );
    logic signed [QW-1:0] d;
    d = QW'(vn >>> DT);
    if (INTEGRATE_POS != 0) begin
      next_pos = POSITION_SIZE'(QW'(p) + d);
    end else begin
      next_pos = p;
    end
  endfunction

  logic [2:0]                       r_state;
  logic [NUM_SOURCES-1:0]           r_en;
  logic [NUM_SOURCES-1:0]           r_done;
  logic                             r_err;
  logic [CW-1:0]                    r_load_cnt;
  logic [CW-1:0]                    r_idx;
  logic [CW-1:0]                    r_src_cnt [NUM_SOURCES];
  logic signed [POSITION_SIZE-1:0]  r_pos_x [NUM_NODES];
  logic signed [POSITION_SIZE-1:0]  r_pos_y [NUM_NODES];
  logic signed [VELOCITY_SIZE-1:0]  r_vel_x [NUM_NODES];
  logic signed [VELOCITY_SIZE-1:0]  r_vel_y [NUM_NODES];
  logic signed [TW-1:0]             r_tot_x [NUM_NODES];
  logic signed [TW-1:0]             r_tot_y [NUM_NODES];
  logic [POSITION_SIZE-1:0]         r_out_px;
  logic [POSITION_SIZE-1:0]         r_out_py;
  logic [VELOCITY_SIZE-1:0]         r_out_vx;
  logic [VELOCITY_SIZE-1:0]         r_out_vy;
  logic                             r_out_valid;
  logic                             r_result;

  logic                             w_window;
  logic [NUM_SOURCES-1:0]           w_hit;
  logic [CW-1:0]                    w_cnt_next [NUM_SOURCES];
  logic                             w_beat_err;
  logic                             w_done_err;
  logic signed [TW-1:0]             w_add_x [NUM_NODES];
  logic signed [TW-1:0]             w_add_y [NUM_NODES];
  logic [IW-1:0]                    w_sel;
  logic signed [VELOCITY_SIZE-1:0]  w_vx_new;
  logic signed [VELOCITY_SIZE-1:0]  w_vy_new;
  logic signed [POSITION_SIZE-1:0]  w_px_new;
  logic signed [POSITION_SIZE-1:0]  w_py_new;

  assign w_window = (r_state == S_LOAD) || (r_state == S_ACCUM);

  // Per-source beat acceptance, overflow/short-stream errors and per-node force sums.
  always_comb begin
    w_beat_err = 1'b0;
    w_done_err = 1'b0;
    for (int s = 0; s < NUM_SOURCES; s++) begin
      w_hit[s]      = w_window && r_en[s] && force_valid_in[s] && (r_src_cnt[s] != FULL);
      w_cnt_next[s] = r_src_cnt[s] + {{(CW-1){1'b0}}, w_hit[s]};
      w_beat_err    = w_beat_err ||
                      (w_window && r_en[s] && force_valid_in[s] && (r_src_cnt[s] == FULL));
      w_done_err    = w_done_err ||
                      (w_window && r_en[s] && force_done_in[s] && (w_cnt_next[s] != FULL));
    end
    for (int i = 0; i < NUM_NODES; i++) begin
      w_add_x[i] = '0;
      w_add_y[i] = '0;
      for (int s = 0; s < NUM_SOURCES; s++) begin
        w_add_x[i] = w_add_x[i] + ((w_hit[s] && (r_src_cnt[s] == CW'(i))) ?
                                   TW'($signed(force_x_in[s])) : TW'(0));
        w_add_y[i] = w_add_y[i] + ((w_hit[s] && (r_src_cnt[s] == CW'(i))) ?
                                   TW'($signed(force_y_in[s])) : TW'(0));
      end
    end
  end

  assign w_sel    = (r_idx < FULL) ? r_idx[IW-1:0] : '0;
  assign w_vx_new = next_vel(r_vel_x[w_sel], r_tot_x[w_sel]);
  assign w_vy_new = next_vel(r_vel_y[w_sel], r_tot_y[w_sel]);
  assign w_px_new = next_pos(r_pos_x[w_sel], w_vx_new);
  assign w_py_new = next_pos(r_pos_y[w_sel], w_vy_new);

  // Step sequencing, node/force capture, accumulation and registered node output.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= S_IDLE;
      r_en        <= '0;
      r_done      <= '0;
      r_err       <= 1'b0;
      r_load_cnt  <= '0;
      r_idx       <= '0;
      r_out_px    <= '0;
      r_out_py    <= '0;
      r_out_vx    <= '0;
      r_out_vy    <= '0;
      r_out_valid <= 1'b0;
      r_result    <= 1'b0;
      for (int s = 0; s < NUM_SOURCES; s++) begin
        r_src_cnt[s] <= '0;
      end
      for (int i = 0; i < NUM_NODES; i++) begin
        r_pos_x[i] <= '0;
        r_pos_y[i] <= '0;
        r_vel_x[i] <= '0;
        r_vel_y[i] <= '0;
        r_tot_x[i] <= '0;
        r_tot_y[i] <= '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      r_result    <= 1'b0;
      for (int i = 0; i < NUM_NODES; i++) begin
        r_tot_x[i] <= r_tot_x[i] + w_add_x[i];
        r_tot_y[i] <= r_tot_y[i] + w_add_y[i];
      end
      for (int s = 0; s < NUM_SOURCES; s++) begin
        r_src_cnt[s] <= w_cnt_next[s];
      end
      if (w_window) begin
        r_done <= r_done | (r_en & force_done_in);
      end
      if (w_beat_err || w_done_err) begin
        r_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (begin_in) begin
            r_en       <= source_enable;
            r_done     <= '0;
            r_err      <= 1'b0;
            r_load_cnt <= '0;
            for (int s = 0; s < NUM_SOURCES; s++) begin
              r_src_cnt[s] <= '0;
            end
            for (int i = 0; i < NUM_NODES; i++) begin
              r_tot_x[i] <= GRAV_X;
              r_tot_y[i] <= GRAV_Y;
            end
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (node_in_valid) begin
            r_pos_x[r_load_cnt[IW-1:0]] <= $signed(node_in_x);
            r_pos_y[r_load_cnt[IW-1:0]] <= $signed(node_in_y);
            r_vel_x[r_load_cnt[IW-1:0]] <= $signed(vel_in_x);
            r_vel_y[r_load_cnt[IW-1:0]] <= $signed(vel_in_y);
            r_load_cnt <= r_load_cnt + {{(CW-1){1'b0}}, 1'b1};
            if (r_load_cnt == LAST) begin
              r_state <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if ((r_done & r_en) == r_en) begin
            r_idx   <= '0;
            r_state <= S_INTEGRATE;
          end
        end
        S_INTEGRATE: begin
          if (r_idx != FULL) begin
            r_out_px    <= w_px_new;
            r_out_py    <= w_py_new;
            r_out_vx    <= w_vx_new;
            r_out_vy    <= w_vy_new;
            r_out_valid <= 1'b1;
            r_idx       <= r_idx + {{(CW-1){1'b0}}, 1'b1};
          end else begin
            r_result <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign node_out_x     = r_out_px;
  assign node_out_y     = r_out_py;
  assign velocity_out_x = r_out_vx;
  assign velocity_out_y = r_out_vy;
  assign out_valid      = r_out_valid;
  assign result_out     = r_result;
  assign error_out      = r_err;
  assign states         = {r_done, r_state};

endmodule

// File: tb/tb_wheel_integrator.sv
// tb_wheel_integrator: directed, table-driven check of wheel_integrator with
// four nodes and three force sources, plus reset and ignored-begin sequences.
module tb_wheel_integrator;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst_in = 1'b0;
  logic              begin_in = 1'b0;
  logic [2:0]        source_enable = 3'b000;
  logic [15:0]       node_in_x = '0, node_in_y = '0, vel_in_x = '0, vel_in_y = '0;
  logic              node_in_valid = 1'b0;
  logic [2:0][15:0]  force_x_in = '0, force_y_in = '0;
  logic [2:0]        force_valid_in = 3'b000, force_done_in = 3'b000;
  logic [15:0]       node_out_x, node_out_y, velocity_out_x, velocity_out_y;
  logic              out_valid, result_out, error_out;
  logic [5:0]        states;

  wheel_integrator #(.NUM_NODES(N)) dut (
    .clk_in(clk), .rst_in(rst_in), .begin_in(begin_in), .source_enable(source_enable),
    .node_in_x(node_in_x), .node_in_y(node_in_y), .vel_in_x(vel_in_x), .vel_in_y(vel_in_y),
    .node_in_valid(node_in_valid), .force_x_in(force_x_in), .force_y_in(force_y_in),
    .force_valid_in(force_valid_in), .force_done_in(force_done_in),
    .node_out_x(node_out_x), .node_out_y(node_out_y),
    .velocity_out_x(velocity_out_x), .velocity_out_y(velocity_out_y),
    .out_valid(out_valid), .result_out(result_out), .error_out(error_out), .states(states)
  );

  always #5 clk = ~clk;

  typedef struct {
    int px, py, vx, vy;
    int fx0, fx1, fx2, fy0, fy1, fy2;
    int ex_px, ex_py, ex_vx, ex_vy;
  } vec_t;

  vec_t tv [20];
  int n_vec = 0, n_bad = 0;
  int cyc = 0;
  int n_out, res_cnt, int_cyc, first_out, res_cyc, res_ov;
  int cap_px [N], cap_py [N], cap_vx [N], cap_vy [N];

  always @(posedge clk) cyc <= cyc + 1;

  // Capture each output beat, the result pulse and the first INTEGRATE cycle.
  always @(negedge clk) begin
    if (out_valid) begin
      if (n_out < N) begin
        cap_px[n_out] = int'($signed(node_out_x));
        cap_py[n_out] = int'($signed(node_out_y));
        cap_vx[n_out] = int'($signed(velocity_out_x));
        cap_vy[n_out] = int'($signed(velocity_out_y));
      end
      if (first_out < 0) first_out = cyc;
      n_out++;
    end
    if (result_out) begin
      res_cnt++;
      res_cyc = cyc;
      res_ov  = int'(out_valid);
    end
    if (states[2:0] == 3'd3 && int_cyc < 0) int_cyc = cyc;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic sv(input int i, input int px, input int py, input int vx, input int vy,
                    input int fx0, input int fx1, input int fx2,
                    input int fy0, input int fy1, input int fy2,
                    input int epx, input int epy, input int evx, input int evy);
    tv[i] = '{px, py, vx, vy, fx0, fx1, fx2, fy0, fy1, fy2, epx, epy, evx, evy};
  endtask

  task automatic clear_inputs();
    node_in_valid  = 1'b0;
    force_valid_in = 3'b000;
    force_done_in  = 3'b000;
    force_x_in     = '0;
    force_y_in     = '0;
  endtask

  // One full step: begin, four node/force beats, wait for result, compare.
  task automatic run_step(input int base, input logic [2:0] en, input bit short0,
                          input bit mid_begin, input int exp_err);
    bit pulsed = 1'b0;
    n_out = 0; res_cnt = 0; int_cyc = -1; first_out = -1; res_cyc = -1; res_ov = 0;
    @(posedge clk); #1;
    begin_in = 1'b1; source_enable = en;
    @(posedge clk); #1;
    begin_in = 1'b0; source_enable = ~en;
    for (int k = 0; k < N; k++) begin
      node_in_valid = 1'b1;
      node_in_x = 16'(tv[base+k].px);  node_in_y = 16'(tv[base+k].py);
      vel_in_x  = 16'(tv[base+k].vx);  vel_in_y  = 16'(tv[base+k].vy);
      force_x_in[0] = 16'(tv[base+k].fx0); force_y_in[0] = 16'(tv[base+k].fy0);
      force_x_in[1] = 16'(tv[base+k].fx1); force_y_in[1] = 16'(tv[base+k].fy1);
      force_x_in[2] = 16'(tv[base+k].fx2); force_y_in[2] = 16'(tv[base+k].fy2);
      force_valid_in = 3'b111;
      force_done_in  = (k == N-1) ? en : 3'b000;
      if (short0) begin
        force_valid_in[0] = (k < N-1);
        force_done_in[0]  = (k == N-2) && en[0];
      end
      if (k == 0) begin
        @(negedge clk);
        chk($sformatf("err_clear@%0d", base), int'(error_out), 0);
      end
      @(posedge clk); #1;
    end
    clear_inputs();
    for (int c = 0; c < 60 && res_cnt == 0; c++) begin
      if (mid_begin && int_cyc >= 0 && !pulsed) begin
        begin_in = 1'b1; source_enable = 3'b010; pulsed = 1'b1;
      end else begin
        begin_in = 1'b0;
      end
      @(posedge clk); #1;
    end
    begin_in = 1'b0;
    chk($sformatf("result_seen@%0d", base), res_cnt, 1);
    chk($sformatf("beats@%0d", base), n_out, N);
    chk($sformatf("first_out_lat@%0d", base), first_out - int_cyc, 1);
    chk($sformatf("result_lat@%0d", base), res_cyc - int_cyc, N + 1);
    chk($sformatf("result_ov@%0d", base), res_ov, 0);
    chk($sformatf("error@%0d", base), int'(error_out), exp_err);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("v%0d.px", base+k), cap_px[k], tv[base+k].ex_px);
      chk($sformatf("v%0d.py", base+k), cap_py[k], tv[base+k].ex_py);
      chk($sformatf("v%0d.vx", base+k), cap_vx[k], tv[base+k].ex_vx);
      chk($sformatf("v%0d.vy", base+k), cap_vy[k], tv[base+k].ex_vy);
    end
    if (mid_begin) begin
      @(negedge clk);
      chk("idle_after_ignored_begin", int'(states[2:0]), 0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Gravity only: a_y = -16>>>4 = -1, p_y = 100 + (-1>>>4) = 99.
    for (int k = 0; k < 4; k++) sv(k, 100,100, 0,0, 0,0,0, 0,0,0, 100,99, 0,-1);
    // Same-cycle hit on node 0: 32+48+16 = 96 -> vx 6, px 100 + 0.
    sv(4, 100,100, 0,0, 32,48,16, 0,0,0, 100,99, 6,-1);
    for (int k = 5; k < 8; k++) sv(k, 100,100, 0,0, 0,0,0, 0,0,0, 100,99, 0,-1);
    // Saturation, mixed y forces, and position wrap.
    sv(8,  100,100,  995,0,  160,0,0, 0,0,0,    162,99,  1000,-1);
    sv(9,  100,100, -995,0, -160,0,0, 0,0,0,     37,99, -1000,-1);
    sv(10, -50,20,   17,-33, 0,0,0,  8,-40,64,  -49,18,    17,-32);
    sv(11, 32767,-32768, 100,0, 0,0,0, 0,0,0, -32763,32767, 100,-1);
    // Enable mask 001: sources 1/2 carry garbage that must not be applied.
    sv(12, 100,100, 0,0, 16,12345,12345, 0,-777,-777,   100,99, 1,-1);
    sv(13, 100,100, 0,0, 16,12345,12345, -32,-777,-777, 100,99, 1,-3);
    sv(14, 100,100, 0,0, 16,12345,12345, 0,-777,-777,   100,99, 1,-1);
    sv(15, 100,100, 0,0, 16,12345,12345, 0,-777,-777,   100,99, 1,-1);
    // Short stream: source 0 stops after 3 beats, node 3 keeps gravity only.
    for (int k = 16; k < 19; k++) sv(k, 100,100, 0,0, 32,0,0, 0,0,0, 100,99, 2,-1);
    sv(19, 100,100, 0,0, 32,0,0, 0,0,0, 100,99, 0,-1);

    rst_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_in = 1'b0;
    @(negedge clk);
    chk("rst.node_out_x", int'(node_out_x), 0);
    chk("rst.out_valid", int'(out_valid), 0);
    chk("rst.result_out", int'(result_out), 0);
    chk("rst.error_out", int'(error_out), 0);
    chk("rst.states", int'(states), 0);

    run_step(0,  3'b111, 1'b0, 1'b0, 0);
    run_step(4,  3'b111, 1'b0, 1'b0, 0);
    run_step(8,  3'b111, 1'b0, 1'b0, 0);
    run_step(12, 3'b001, 1'b0, 1'b0, 0);
    run_step(16, 3'b111, 1'b1, 1'b0, 1);

    // Reset in the middle of ACCUM after an early done raised error_out.
    @(posedge clk); #1;
    begin_in = 1'b1; source_enable = 3'b111;
    @(posedge clk); #1;
    begin_in = 1'b0;
    for (int k = 0; k < N; k++) begin
      node_in_valid = 1'b1;
      node_in_x = 16'd100; node_in_y = 16'd100; vel_in_x = 16'd0; vel_in_y = 16'd0;
      force_valid_in = 3'b111;
      force_done_in  = (k == 0) ? 3'b001 : 3'b000;
      @(posedge clk); #1;
    end
    clear_inputs();
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst.state_accum", int'(states[2:0]), 2);
    chk("pre_rst.error_out", int'(error_out), 1);
    @(posedge clk); #1 rst_in = 1'b1;
    @(posedge clk); #1 rst_in = 1'b0;
    @(negedge clk);
    chk("mid_rst.node_out_x", int'(node_out_x), 0);
    chk("mid_rst.node_out_y", int'(node_out_y), 0);
    chk("mid_rst.velocity_out_x", int'(velocity_out_x), 0);
    chk("mid_rst.velocity_out_y", int'(velocity_out_y), 0);
    chk("mid_rst.error_out", int'(error_out), 0);
    chk("mid_rst.states", int'(states), 0);
    res_cnt = 0;
    repeat (8) @(posedge clk);
    #1;
    chk("mid_rst.no_result", res_cnt, 0);

    // Following step with a begin pulse during INTEGRATE that must be ignored.
    run_step(0, 3'b111, 1'b0, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
